// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles big-endian byte stream into 32-bit words,
// writes them sequentially from ADDR_BASE and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [8:0]  WORD_COUNT,
    input  logic        ABORT,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        CPU_RESET,
    output logic        BUSY,
    output logic        DONE
);

    // state   | meaning
    // IDLE    | waiting for START
    // COLLECT | accepting the four bytes of the current word
    // WRITE   | one-cycle write strobe for the assembled word
    // FINISH  | one-cycle DONE pulse, releases CPU_RESET
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [8:0]  MAX_CNT   = 9'(MAX_WORDS);
    localparam logic [31:0] ADDR_LAST = ADDR_BASE + 32'(4 * (MAX_WORDS - 1));

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  word_cnt;
    logic [8:0]  words_done;
    logic [1:0]  byte_idx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        cpu_reset_q;
    logic [8:0]  cnt_clamped;
    logic        accept;
    logic        last_word;

    assign cnt_clamped = (WORD_COUNT > MAX_CNT) ? MAX_CNT : WORD_COUNT;
    assign accept      = (state == COLLECT) && BYTE_VALID && !ABORT;
    assign last_word   = (words_done + 9'd1) == word_cnt;

    assign BYTE_READY = (state == COLLECT);
    assign MEM_WE     = (state == WRITE) && !ABORT;
    assign BUSY       = (state == COLLECT) || (state == WRITE);
    assign DONE       = (state == FINISH);
    assign MEM_ADDR   = addr_q;
    assign MEM_WDATA  = wdata_q;
    assign CPU_RESET  = cpu_reset_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = (cnt_clamped == 9'd0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (ABORT) begin
                    state_nxt = IDLE;
                end else if (BYTE_VALID && (byte_idx == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (ABORT) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = last_word ? FINISH : COLLECT;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            word_cnt    <= '0;
            words_done  <= '0;
            byte_idx    <= '0;
            addr_q      <= ADDR_BASE;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        word_cnt    <= cnt_clamped;
                        words_done  <= '0;
                        byte_idx    <= '0;
                        addr_q      <= ADDR_BASE;
                        cpu_reset_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (ABORT) begin
                        byte_idx <= '0;
                    end else if (accept) begin
                        case (byte_idx)
                            2'd0:    wdata_q[31:24] <= BYTE_IN;
                            2'd1:    wdata_q[23:16] <= BYTE_IN;
                            2'd2:    wdata_q[15:8]  <= BYTE_IN;
                            default: wdata_q[7:0]   <= BYTE_IN;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    byte_idx <= '0;
                    if (!ABORT) begin
                        words_done <= words_done + 9'd1;
                        // saturate so the final increment cannot step past the top word
                        if (addr_q != ADDR_LAST) begin
                            addr_q <= addr_q + 32'd4;
                        end
                    end
                end
                FINISH: begin
                    cpu_reset_q <= 1'b0;
                end
                default: begin
                    byte_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte source with optional stall, write/DONE monitor,
// immediate-assertion checks against hand-computed cycle numbers and words.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [8:0]  WORD_COUNT;
    logic        ABORT;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        CPU_RESET;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s = 0;

    logic [7:0]  src_q[$];
    int          sent = 0;
    int          gap_idx = -1;
    int          gap_rem = 0;
    logic        will_acc = 1'b0;

    logic [31:0] we_cyc[$];
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    logic [31:0] done_q[$];
    int          cr_fall = -1;
    logic        prev_cr = 1'b1;

    imem_loader #(.ADDR_BASE(32'h0), .MAX_WORDS(256)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .WORD_COUNT(WORD_COUNT),
        .ABORT(ABORT), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
        .BYTE_READY(BYTE_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .CPU_RESET(CPU_RESET), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // byte source: decides at negedge what the next posedge will sample
    always @(negedge CLK) begin
        if (will_acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            sent++;
        end
        if (src_q.size() > 0 && !(sent == gap_idx && gap_rem > 0)) begin
            BYTE_VALID = 1'b1;
            BYTE_IN    = src_q[0];
        end else begin
            BYTE_VALID = 1'b0;
            if (src_q.size() > 0 && gap_rem > 0) gap_rem--;
        end
        will_acc = BYTE_VALID && BYTE_READY;
    end

    always @(negedge CLK) begin
        if (MEM_WE) begin
            we_cyc.push_back(32'(cyc));
            we_addr.push_back(MEM_ADDR);
            we_data.push_back(MEM_WDATA);
        end
        if (DONE) done_q.push_back(32'(cyc));
        if (prev_cr && !CPU_RESET) cr_fall = cyc;
        prev_cr = CPU_RESET;
    end

    function automatic logic [31:0] qw(input logic [31:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 32'hxxxx_xxxx;
        return q[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        we_cyc.delete();
        we_addr.delete();
        we_data.delete();
        done_q.delete();
        cr_fall = -1;
    endtask

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w[31:24]);
        src_q.push_back(w[23:16]);
        src_q.push_back(w[15:8]);
        src_q.push_back(w[7:0]);
    endtask

    // START sampled at the posedge ending cycle s; returns at the negedge of cycle s+1
    task automatic start_load(input logic [8:0] n);
        @(negedge CLK);
        START      = 1'b1;
        WORD_COUNT = n;
        s          = cyc;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        START = 1'b0;
        WORD_COUNT = '0;
        ABORT = 1'b0;
        #12;
        chk("rst_we", 32'(MEM_WE), 32'd0);
        chk("rst_ready", 32'(BYTE_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_addr", MEM_ADDR, 32'h0);
        chk("rst_wdata", MEM_WDATA, 32'h0);
        chk("rst_cpu_reset", 32'(CPU_RESET), 32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_ready", 32'(BYTE_READY), 32'd0);

        // two-word load, bytes streamed back to back
        clear_mon();
        sent = 0;
        push_word(32'h0001_1020);
        push_word(32'h0064_2824);
        start_load(9'd2);
        chk("w2_busy", 32'(BUSY), 32'd1);
        repeat (14) @(negedge CLK);
        chk("w2_nwe", 32'(we_cyc.size()), 32'd2);
        chk("w2_cyc0", qw(we_cyc, 0), 32'(s + 5));
        chk("w2_addr0", qw(we_addr, 0), 32'h0);
        chk("w2_data0", qw(we_data, 0), 32'h0001_1020);
        chk("w2_cyc1", qw(we_cyc, 1), 32'(s + 10));
        chk("w2_addr1", qw(we_addr, 1), 32'h4);
        chk("w2_data1", qw(we_data, 1), 32'h0064_2824);
        chk("w2_done", qw(done_q, 0), 32'(s + 11));
        chk("w2_ndone", 32'(done_q.size()), 32'd1);
        chk("w2_crfall", 32'(cr_fall), 32'(s + 12));

        // three-cycle stall between bytes 1 and 2
        clear_mon();
        sent = 0;
        gap_idx = 2;
        gap_rem = 3;
        push_word(32'hDEAD_BEEF);
        start_load(9'd1);
        repeat (12) @(negedge CLK);
        chk("bp_nwe", 32'(we_cyc.size()), 32'd1);
        chk("bp_cyc", qw(we_cyc, 0), 32'(s + 8));
        chk("bp_data", qw(we_data, 0), 32'hDEAD_BEEF);
        chk("bp_addr", qw(we_addr, 0), 32'h0);
        chk("bp_done", qw(done_q, 0), 32'(s + 9));
        gap_idx = -1;

        // zero count
        clear_mon();
        start_load(9'd0);
        repeat (4) @(negedge CLK);
        chk("z_nwe", 32'(we_cyc.size()), 32'd0);
        chk("z_done", qw(done_q, 0), 32'(s + 1));
        chk("z_cpu_reset", 32'(CPU_RESET), 32'd0);
        chk("z_crfall", 32'(cr_fall), 32'(s + 2));

        // abort after two bytes of word 1
        clear_mon();
        sent = 0;
        push_word(32'h1122_3344);
        push_word(32'h5566_7788);
        push_word(32'h99AA_BBCC);
        start_load(9'd3);
        repeat (7) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("ab_busy", 32'(BUSY), 32'd0);
        chk("ab_we", 32'(MEM_WE), 32'd0);
        repeat (3) @(negedge CLK);
        src_q.delete();
        sent = 0;
        repeat (10) @(negedge CLK);
        chk("ab_nwe", 32'(we_cyc.size()), 32'd1);
        chk("ab_data0", qw(we_data, 0), 32'h1122_3344);
        chk("ab_ndone", 32'(done_q.size()), 32'd0);
        chk("ab_cpu_reset", 32'(CPU_RESET), 32'd1);
        clear_mon();
        push_word(32'hA1A2_A3A4);
        start_load(9'd1);
        repeat (8) @(negedge CLK);
        chk("ab2_nwe", 32'(we_cyc.size()), 32'd1);
        chk("ab2_addr", qw(we_addr, 0), 32'h0);
        chk("ab2_data", qw(we_data, 0), 32'hA1A2_A3A4);
        chk("ab2_ndone", 32'(done_q.size()), 32'd1);

        // clamp 300 down to 256 words
        clear_mon();
        sent = 0;
        for (int k = 0; k < 1280; k++) src_q.push_back(8'(k));
        start_load(9'd300);
        repeat (1290) @(negedge CLK);
        chk("cl_nwe", 32'(we_cyc.size()), 32'd256);
        chk("cl_first_addr", qw(we_addr, 0), 32'h0);
        chk("cl_last_addr", qw(we_addr, 255), 32'h3FC);
        chk("cl_last_data", qw(we_data, 255), 32'hFCFD_FEFF);
        chk("cl_last_cyc", qw(we_cyc, 255), 32'(s + 1280));
        chk("cl_done", qw(done_q, 0), 32'(s + 1281));
        chk("cl_addr_hold", MEM_ADDR, 32'h3FC);
        src_q.delete();

        // asynchronous reset in the middle of a WRITE
        clear_mon();
        sent = 0;
        push_word(32'h0102_0304);
        start_load(9'd1);
        repeat (4) @(negedge CLK);
        chk("rw_we_before", 32'(MEM_WE), 32'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rw_we", 32'(MEM_WE), 32'd0);
        chk("rw_busy", 32'(BUSY), 32'd0);
        chk("rw_ready", 32'(BYTE_READY), 32'd0);
        chk("rw_done", 32'(DONE), 32'd0);
        chk("rw_addr", MEM_ADDR, 32'h0);
        chk("rw_wdata", MEM_WDATA, 32'h0);
        chk("rw_cpu_reset", 32'(CPU_RESET), 32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        src_q.delete();
        repeat (4) @(negedge CLK);
        chk("rw_idle_busy", 32'(BUSY), 32'd0);
        chk("rw_idle_ready", 32'(BYTE_READY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
